// File: rtl/pulse_transmitter_symbol_sequencer.sv
// pulse_transmitter_symbol_sequencer: replays a buffer of {level,duration} symbols through a countdown timer.
// Define PULSE_TRANSMITTER_SEQ_LOOP_EN to honour loop_count (extra passes); otherwise one pass per start.
module pulse_transmitter_symbol_sequencer #(
   parameter int DEPTH           = 8,
   parameter int PRESCALER_WIDTH = 16,
   parameter int TIMER_WIDTH     = 8
) (
   input  logic                               clk,
   input  logic                               sys_rst,
   input  logic                               wr_en,
   input  logic [$clog2(DEPTH)-1:0]           wr_addr,
   input  logic [TIMER_WIDTH:0]               wr_data,
   input  logic [$clog2(DEPTH)-1:0]           last_idx,
   input  logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler,
   input  logic                               idle_level,
   input  logic [7:0]                         loop_count,
   input  logic                               start,
   input  logic                               stop,
   input  logic                               timer_pulse,
   output logic                               timer_en,
   output logic [$clog2(PRESCALER_WIDTH)-1:0] timer_prescaler,
   output logic [TIMER_WIDTH-1:0]             timer_duration,
   output logic                               pin_out,
   output logic                               busy,
   output logic                               done
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(PRESCALER_WIDTH);
   localparam int TW = TIMER_WIDTH;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d, last_q, last_d, nidx;
   logic [PW-1:0]   tpre_q, tpre_d;
   logic [TW-1:0]   tdur_q, tdur_d;
   logic            pin_q, pin_d, done_q, done_d, ld;
   logic [TW:0]     mem_q [DEPTH], mem_d [DEPTH];
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
   logic [7:0]      pass_q, pass_d;
`else
   logic            unused_loop;
   assign unused_loop = ^loop_count;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      tpre_d  = tpre_q;
      tdur_d  = tdur_q;
      pin_d   = pin_q;
      done_d  = 1'b0;
      nidx    = idx_q + 1'b1;
      ld      = 1'b0;
      mem_d   = mem_q;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
      pass_d  = pass_q;
`endif
      if (wr_en && state_q == IDLE) mem_d[wr_addr] = wr_data;
      case (state_q)
         IDLE: begin
            pin_d = idle_level;
            if (start && !stop) begin
               nidx   = '0;
               ld     = 1'b1;
               last_d = last_idx;
               tpre_d = prescaler;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
               pass_d = loop_count;
`endif
            end
         end
         LOAD: state_d = stop ? IDLE : RUN;
         default: begin
            if (stop) state_d = IDLE;
            else if (timer_pulse) begin
               if (idx_q != last_q) ld = 1'b1;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
               else if (pass_q != 8'd0) begin
                  pass_d = pass_q - 8'd1;
                  nidx   = '0;
                  ld     = 1'b1;
               end
`endif
               else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
      // Leaving a sequence (stop or completion) returns the pin to idle on the same edge
      if (state_d == IDLE && state_q != IDLE) pin_d = idle_level;
      if (ld) begin
         state_d = LOAD;
         idx_d   = nidx;
         pin_d   = mem_q[nidx][TW];
         tdur_d  = mem_q[nidx][TW-1:0];
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         tpre_q  <= '0;
         tdur_q  <= '0;
         pin_q   <= 1'b0;
         done_q  <= 1'b0;
         mem_q   <= '{default: '0};
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
         pass_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         tpre_q  <= tpre_d;
         tdur_q  <= tdur_d;
         pin_q   <= pin_d;
         done_q  <= done_d;
         mem_q   <= mem_d;
`ifdef PULSE_TRANSMITTER_SEQ_LOOP_EN
         pass_q  <= pass_d;
`endif
      end
   end

   assign timer_en        = (state_q == RUN);
   assign busy            = (state_q != IDLE);
   assign timer_prescaler = tpre_q;
   assign timer_duration  = tdur_q;
   assign pin_out         = pin_q;
   assign done            = done_q;
endmodule
